// File: rtl/finv_latter_if.sv
// Handshake bundle between finv_former / finv_latter and the FPU result mux.
interface finv_latter_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] s;
  logic [63:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] d;

  // Producer / consumer side (drives operands, accepts results)
  modport master (
    output in_valid, s, x, out_ready,
    input  in_ready, out_valid, d
  );

  // finv_latter side
  modport slave (
    input  in_valid, s, x, out_ready,
    output in_ready, out_valid, d
  );
endinterface

// File: rtl/finv_latter.sv
// Second stage of the single-precision reciprocal: one Newton refinement of the
// 2/m estimate on a shared 64-bit multiplier, then special cases, normalise,
// round-to-nearest-even and pack. Fixed latency, valid/ready on both sides.
module finv_latter (
  input  logic         clk,
  input  logic         rst,
  finv_latter_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StMul1, StMul2, StSub, StPack, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] s_q, s_d;
  logic [63:0] m_q, m_d;    // {1,mant} in Q.31
  logic [32:0] y_q, y_d;    // first estimate of 2/m, Q.31
  logic [63:0] c_q, c_d;    // m*y, Q.31
  logic [63:0] e_q, e_d;    // c*y, Q.30
  logic [32:0] y2_q, y2_d;  // refined 2/m, Q.31
  logic [31:0] d_q, d_d;

  logic [63:0] mul_a, mul_b, prod;
  logic [63:0] y2_full;
  logic [31:0] pack_res;

  logic              sign_w;
  logic [7:0]        bexp;
  logic [22:0]       mant;
  logic [22:0]       frac;
  logic              guard, rnd, sticky, rnd_inc;
  logic [23:0]       frac_inc;
  logic signed [9:0] exp_v;

  // Single multiplier: m*y in MUL1, c*y in MUL2; product truncated to 64 bits
  assign mul_a   = (state_q == StMul2) ? c_q : m_q;
  assign mul_b   = {31'd0, y_q};
  assign prod    = mul_a * mul_b;
  assign y2_full = ({31'd0, y_q} << 1) - e_q;

  // Bits that are architecturally dropped (upper x, truncated product/difference)
  logic unused_bits;
  assign unused_bits = ^{bus.x[63:33], prod[30:0], y2_full[63:33], exp_v[9:8]};

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.in_valid) state_d = StMul1;
      StMul1:  state_d = StMul2;
      StMul2:  state_d = StSub;
      StSub:   state_d = StPack;
      StPack:  state_d = StDone;
      StDone:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: ready only in IDLE, result presented only in DONE
  always_comb begin
    bus.in_ready  = (state_q == StIdle);
    bus.out_valid = (state_q == StDone);
    bus.d         = d_q;
  end

  // Datapath next-state: each register loads only in its own state
  always_comb begin
    s_d  = s_q;
    m_d  = m_q;
    y_d  = y_q;
    c_d  = c_q;
    e_d  = e_q;
    y2_d = y2_q;
    d_d  = d_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          s_d = bus.s;
          m_d = {32'd0, 1'b1, bus.s[22:0], 8'd0};
          y_d = bus.x[32:0];
        end
      end
      StMul1:  c_d  = {31'd0, prod[63:31]};
      StMul2:  e_d  = {32'd0, prod[63:32]};
      StSub:   y2_d = y2_full[32:0];
      StPack:  d_d  = pack_res;
      default: ;
    endcase
  end

  // Special-case decode, normalisation and round-to-nearest-even of y2
  always_comb begin
    sign_w = s_q[31];
    bexp   = s_q[30:23];
    mant   = s_q[22:0];
    if (y2_q[32]) begin
      frac   = y2_q[31:9];
      guard  = y2_q[8];
      rnd    = y2_q[7];
      sticky = |y2_q[6:0];
      exp_v  = 10'sd254 - $signed({2'b00, bexp});
    end else begin
      frac   = y2_q[30:8];
      guard  = y2_q[7];
      rnd    = y2_q[6];
      sticky = |y2_q[5:0];
      exp_v  = 10'sd253 - $signed({2'b00, bexp});
    end
    rnd_inc  = guard & (rnd | sticky | frac[0]);
    frac_inc = {1'b0, frac} + {23'd0, rnd_inc};
    // Mantissa carry-out leaves frac_inc[22:0] at zero, so only the exponent moves
    if (frac_inc[23]) begin
      exp_v = exp_v + 10'sd1;
    end
    if (bexp == 8'hFF) begin
      pack_res = (mant != 23'd0) ? 32'h7FC0_0000 : {sign_w, 31'd0};
    end else if (bexp == 8'h00) begin
      pack_res = {sign_w, 8'hFF, 23'd0};
    end else if (exp_v <= 10'sd0) begin
      pack_res = {sign_w, 31'd0};
    end else begin
      pack_res = {sign_w, exp_v[7:0], frac_inc[22:0]};
    end
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q  <= '0;
      m_q  <= '0;
      y_q  <= '0;
      c_q  <= '0;
      e_q  <= '0;
      y2_q <= '0;
      d_q  <= '0;
    end else begin
      s_q  <= s_d;
      m_q  <= m_d;
      y_q  <= y_d;
      c_q  <= c_d;
      e_q  <= e_d;
      y2_q <= y2_d;
      d_q  <= d_d;
    end
  end

endmodule

// File: tb/tb_finv_latter.sv
// Directed and random checks of finv_latter with a scoreboard of expected results.
module tb_finv_latter;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;
  int unsigned xfers = 0;
  int          checks = 0;
  int          errors = 0;

  logic [31:0] exp_q[$];
  bit          tol_q[$];

  finv_latter_if bus();

  finv_latter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Cycle counter and output transfer counter
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.out_valid && bus.out_ready) xfers <= xfers + 1;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Pop the oldest expected result and compare, optionally allowing 1 ulp
  task automatic check_d(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    bit          t;
    bit          ok;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    t = (tol_q.size() > 0) ? tol_q.pop_front() : 1'b0;
    ok = (obs === e) ||
         (t && (obs[31] == e[31]) && (((obs - e) == 32'd1) || ((e - obs) == 32'd1)));
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  // Stand-in for finv_former: slight underestimate of 2/m in Q.31, junk in x[63:33]
  function automatic logic [63:0] former(input logic [31:0] sv);
    logic [63:0] mq, est, junk;
    mq   = {32'd0, 1'b1, sv[22:0], 8'd0};
    est  = ((64'h8000_0000_0000_0000 / mq) - 64'd1) & ~64'hFF;
    junk = {$urandom, $urandom} & 64'hFFFF_FFFE_0000_0000;
    return est | junk;
  endfunction

  // Correctly rounded 1/s by long division (flush-to-zero semantics)
  function automatic logic [31:0] ref_finv(input logic [31:0] sv);
    logic        sg;
    logic [7:0]  ex;
    logic [22:0] mn;
    logic [63:0] r, rem, mm;
    logic [23:0] fr;
    int          ev;
    bit          g, st, inc;
    sg = sv[31];
    ex = sv[30:23];
    mn = sv[22:0];
    if (ex == 8'hFF) return (mn != 23'd0) ? 32'h7FC0_0000 : {sg, 31'd0};
    if (ex == 8'h00) return {sg, 8'hFF, 23'd0};
    if (mn == 23'd0) begin
      ev = 254 - int'(ex);
      fr = 24'd0;
    end else begin
      mm  = {40'd0, 1'b1, mn};
      r   = (64'd1 << 48) / mm;
      rem = (64'd1 << 48) % mm;
      fr  = {1'b0, r[23:1]};
      g   = r[0];
      st  = (rem != 64'd0);
      ev  = 253 - int'(ex);
      inc = g & (st | fr[0]);
      fr  = fr + {23'd0, inc};
      if (fr[23]) begin
        ev++;
        fr = 24'd0;
      end
    end
    if (ev <= 0) return {sg, 31'd0};
    return {sg, ev[7:0], fr[22:0]};
  endfunction

  // One full transaction with out_ready high; checks accept, latency and result
  task automatic do_op(input string tag, input logic [31:0] sv, input logic [31:0] expv,
                       input bit tol);
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "/in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.s         = sv;
    bus.x         = former(sv);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    exp_q.push_back(expv);
    tol_q.push_back(tol);
    tick();
    // Operands change right after the accept edge; the result must not care
    bus.in_valid = 1'b0;
    bus.s        = $urandom;
    bus.x        = {$urandom, $urandom};
    check({tag, "/busy"}, 64'(bus.in_ready), 64'd0);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "/latency"}, 64'(n), 64'd4);
    check_d({tag, "/d"}, bus.d);
    tick();
  endtask

  initial begin
    logic [31:0] d0;
    logic [31:0] cur;
    int unsigned x0;
    int unsigned acc_prev;
    int          n;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.s         = '0;
    bus.x         = '0;
    tick();
    tick();
    check("reset/in_ready", 64'(bus.in_ready), 64'd1);
    check("reset/out_valid", 64'(bus.out_valid), 64'd0);
    check("reset/d", 64'(bus.d), 64'd0);
    rst = 1'b0;
    tick();

    // Normals
    do_op("one",   32'h3F80_0000, 32'h3F80_0000, 1'b0);
    do_op("two",   32'h4000_0000, 32'h3F00_0000, 1'b0);
    do_op("neg4",  32'hC080_0000, 32'hBE80_0000, 1'b0);
    do_op("three", 32'h4040_0000, 32'h3EAA_AAAB, 1'b1);

    // Specials
    do_op("pzero", 32'h0000_0000, 32'h7F80_0000, 1'b0);
    do_op("nzero", 32'h8000_0000, 32'hFF80_0000, 1'b0);
    do_op("denorm", 32'h0000_0001, 32'h7F80_0000, 1'b0);
    do_op("pinf",  32'h7F80_0000, 32'h0000_0000, 1'b0);
    do_op("ninf",  32'hFF80_0000, 32'h8000_0000, 1'b0);
    do_op("nan",   32'h7FC0_0001, 32'h7FC0_0000, 1'b0);

    // Underflow boundary
    do_op("p127",  32'h7F00_0000, 32'h0000_0000, 1'b0);
    do_op("p126",  32'h7E80_0000, 32'h0080_0000, 1'b0);
    do_op("maxf",  32'h7F7F_FFFF, 32'h0000_0000, 1'b0);

    // Backpressure: hold result for 10 cycles while in_valid pulses
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    bus.s         = 32'h4040_0000;
    bus.x         = former(32'h4040_0000);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    exp_q.push_back(32'h3EAA_AAAB);
    tol_q.push_back(1'b1);
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    check("bp/latency", 64'(n), 64'd4);
    d0 = bus.d;
    x0 = xfers;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.s        = 32'h3F80_0000;
      bus.x        = former(32'h3F80_0000);
      tick();
      check("bp/d_hold", 64'(bus.d), 64'(d0));
      check("bp/out_valid", 64'(bus.out_valid), 64'd1);
      check("bp/in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check_d("bp/d", bus.d);
    tick();
    check("bp/in_ready_after", 64'(bus.in_ready), 64'd1);
    check("bp/out_valid_after", 64'(bus.out_valid), 64'd0);
    check("bp/one_xfer", 64'(xfers - x0), 64'd1);
    for (int i = 0; i < 6; i++) tick();
    check("bp/no_ghost", 64'(bus.out_valid), 64'd0);
    check("bp/one_xfer_late", 64'(xfers - x0), 64'd1);

    // Reset during MUL2 aborts the operation
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    bus.s         = 32'h4000_0000;
    bus.x         = former(32'h4000_0000);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst/out_valid", 64'(bus.out_valid), 64'd0);
    check("rst/in_ready", 64'(bus.in_ready), 64'd1);
    check("rst/d", 64'(bus.d), 64'd0);
    do_op("rst/after", 32'h4000_0000, 32'h3F00_0000, 1'b0);

    // Back-to-back stream with in_valid held high
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.s = {1'($urandom_range(0, 1)), 8'($urandom_range(2, 250)), 23'($urandom)};
    bus.x = former(bus.s);
    acc_prev = 0;
    for (int i = 0; i < 100; i++) begin
      n = 0;
      while (!bus.in_ready && n < 20) begin
        tick();
        n++;
      end
      check("b2b/in_ready", 64'(bus.in_ready), 64'd1);
      cur = bus.s;
      exp_q.push_back(ref_finv(cur));
      tol_q.push_back(1'b1);
      tick();
      // DONE cycle and one IDLE cycle separate consecutive accepts
      if (i > 0) check("b2b/spacing", 64'(cyc - acc_prev), 64'd6);
      acc_prev = cyc;
      bus.s = {1'($urandom_range(0, 1)), 8'($urandom_range(2, 250)), 23'($urandom)};
      bus.x = former(bus.s);
      n = 0;
      while (!bus.out_valid && n < 20) begin
        tick();
        n++;
      end
      check("b2b/latency", 64'(n), 64'd4);
      check_d("b2b/d", bus.d);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
